// File: rtl/byte_computer_pkg.sv
// byte_computer_pkg: shared sizes, loader FSM states and opcodes for the 8-bit accumulator computer.
package byte_computer_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} loader_state_t;
    localparam logic [7:0] HALT_INSTR = 8'hFF;
endpackage

// File: rtl/prog_ram.sv
// prog_ram: DEPTH x DATA_W RAM, one synchronous write port, two asynchronous read ports.
module prog_ram #(
    parameter int ADDR_W = byte_computer_pkg::ADDR_W,
    parameter int DATA_W = byte_computer_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/program_loader.sv
// program_loader: host image load, CPU run supervision with watchdog, and RAM dump back to the host.
module program_loader #(
    parameter int ADDR_W     = byte_computer_pkg::ADDR_W,
    parameter int DATA_W     = byte_computer_pkg::DATA_W,
    parameter int MAX_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              cpu_rst,
    output logic              cpu_start,
    input  logic              cpu_halt,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_odata,
    output logic [DATA_W-1:0] cpu_idata,
    output logic              busy,
    output logic              timeout,
    output logic              done
);
    import byte_computer_pkg::*;

    localparam int CNT_W = $clog2(MAX_CYCLES);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(2 ** ADDR_W - 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    loader_state_t state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, cpu_rst_q, cpu_rst_d;
    logic cpu_start_q, cpu_start_d, busy_q, busy_d, timeout_q, timeout_d, done_q, done_d;
    logic load_go, in_fire, out_fire, wd_hit, ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign load_go  = state_q == IDLE && load_req;
    assign in_fire  = state_q == LOAD && in_valid && in_ready_q;
    assign out_fire = state_q == DUMP && out_valid_q && out_ready;
    assign wd_hit   = state_q == RUN && cycle_cnt_q == WD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cycle_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cpu_rst_q   <= 1'b1;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cycle_cnt_q <= cycle_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cpu_rst_q   <= cpu_rst_d;
            cpu_start_q <= cpu_start_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_req) state_d = LOAD;
            LOAD:    if (in_fire && wr_ptr_q == LAST) state_d = RUN;
            RUN:     if (cpu_halt || wd_hit) state_d = DUMP;
            DUMP:    if (out_fire && rd_ptr_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they change on the same edge as the FSM.
    always_comb begin
        wr_ptr_d    = load_go ? '0 : in_fire ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d    = (state_d == DUMP && state_q != DUMP) ? '0 : out_fire ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        cycle_cnt_d = state_q == RUN ? cycle_cnt_q + CNT_W'(1) : '0;
        in_ready_d  = state_d == LOAD;
        out_valid_d = state_d == DUMP;
        cpu_rst_d   = state_d != RUN;
        cpu_start_d = state_d == RUN;
        busy_d      = state_d != IDLE;
        done_d      = state_q == DUMP && state_d == IDLE;
        timeout_d   = load_go ? 1'b0 : (wd_hit && !cpu_halt) ? 1'b1 : timeout_q;
    end

    assign ram_we    = !rst && (in_fire || (state_q == RUN && cpu_we));
    assign ram_waddr = state_q == LOAD ? wr_ptr_q : cpu_addr;
    assign ram_wdata = state_q == LOAD ? in_data : cpu_odata;

    prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .raddr_a_i (cpu_addr),
        .rdata_a_o (cpu_idata),
        .raddr_b_i (rd_ptr_q),
        .rdata_b_o (out_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && rd_ptr_q == LAST;
    assign cpu_rst   = cpu_rst_q;
    assign cpu_start = cpu_start_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign done      = done_q;
endmodule
